hdb3_decoder: RTL

//   Receive-side HDB3 decoder: takes the bipolar P/N rail pair produced by the transmit polarity

---
 rtl/hdb3_decoder_pkg.sv | 33 +++
 rtl/hdb3_err_chk.sv | 51 +++++
 rtl/hdb3_decoder.sv | 87 ++++++++
 3 files changed

// File: rtl/hdb3_decoder_pkg.sv
// Shared HDB3 line-code definitions: rail-pair codes, pulse polarity and
// small helpers used by the decoder and its line-code checker.
package hdb3_decoder_pkg;

    // Rail pair {P, N} as delivered by the line receiver/slicer.
    localparam logic [1:0] PN_ZERO = 2'b00;
    localparam logic [1:0] PN_NEG  = 2'b01;
    localparam logic [1:0] PN_POS  = 2'b10;
    localparam logic [1:0] PN_ILL  = 2'b11;

    typedef enum logic {
        POL_NEG = 1'b0,
        POL_POS = 1'b1
    } pol_t;

    // A rail pair carries a pulse only for the two legal single-rail codes;
    // the illegal both-rails code is treated as a zero symbol.
    function automatic logic rail_mark(input logic [1:0] pn);
        logic mark;
        case (pn)
            PN_POS, PN_NEG:  mark = 1'b1;
            PN_ZERO, PN_ILL: mark = 1'b0;
            default:         mark = 1'b0;
        endcase
        return mark;
    endfunction

    // Polarity of a pulse; only meaningful when rail_mark() is true.
    function automatic pol_t rail_pol(input logic [1:0] pn);
        return (pn == PN_POS) ? POL_POS : POL_NEG;
    endfunction

endpackage

// File: rtl/hdb3_err_chk.sv
// HDB3 line-code checker. Flags illegal both-rails symbols, V pulses that
// fail to alternate in polarity, and zero runs longer than HDB_N.
// Only instantiated when HDB3_ERR_CHK_EN is defined.
module hdb3_err_chk
    import hdb3_decoder_pkg::*;
#(
    parameter int HDB_N = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] pn,
    input  logic       v_det,
    output logic       code_err
);

    localparam int             ZW      = $clog2(HDB_N + 2);
    localparam logic [ZW-1:0]  RUN_MAX = ZW'(HDB_N + 1);

    pol_t          last_v_pol;
    logic [ZW-1:0] zero_run;
    logic          is_zero;
    logic          ill;
    logic          v_rep;
    logic          run_hit;

    assign is_zero = !rail_mark(pn);
    assign ill     = (pn == PN_ILL);
    assign v_rep   = v_det && (rail_pol(pn) == last_v_pol);
    // Fires only on the symbol that takes the run to HDB_N+1, not on later zeros.
    assign run_hit = is_zero && (zero_run == RUN_MAX - 1'b1);

    // Track V polarity and zero run length; merge all causes into one strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_v_pol <= POL_NEG;
            zero_run   <= '0;
            code_err   <= 1'b0;
        end else begin
            code_err <= ill || v_rep || run_hit;
            if (v_det) begin
                last_v_pol <= rail_pol(pn);
            end
            if (!is_zero) begin
                zero_run <= '0;
            end else if (zero_run != RUN_MAX) begin
                zero_run <= zero_run + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hdb3_decoder.sv
// HDB3 receive decoder: bipolar rail pair in, NRZ bit stream out.
// A V pulse (same polarity as the previous pulse) is detected on arrival and
// both it and the B/0 HDB_N symbols earlier are zeroed inside the delay line.
// Optional line-code checking is enabled with the macro HDB3_ERR_CHK_EN.
module hdb3_decoder
    import hdb3_decoder_pkg::*;
#(
    parameter int HDB_N = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic data_inP,
    input  logic data_inN,
    output logic data_out,
    output logic out_valid,
    output logic code_err
);

    localparam int            FW       = $clog2(HDB_N + 2);
    localparam logic [FW-1:0] FILL_MAX = FW'(HDB_N + 1);

    logic [1:0]    pn;
    logic          mark_in;
    pol_t          pol_in;
    pol_t          last_pol;
    logic          v_det;
    logic [HDB_N:0] sr;
    logic [HDB_N:0] sr_next;
    logic [FW-1:0] fill;
    logic [FW-1:0] fill_next;
    logic          full_next;

    assign pn      = {data_inP, data_inN};
    assign mark_in = rail_mark(pn);
    assign pol_in  = rail_pol(pn);
    assign v_det   = mark_in && (pol_in == last_pol);

    // Next delay-line contents: shift in the mark, and on a V clear both the
    // V itself and the substitution pulse/zero now leaving the far end.
    always_comb begin
        sr_next = {sr[HDB_N-1:0], mark_in};
        if (v_det) begin
            sr_next[0]     = 1'b0;
            sr_next[HDB_N] = 1'b0;
        end
    end

    // Count real symbols since reset until the delay line is full.
    always_comb begin
        fill_next = (fill == FILL_MAX) ? fill : fill + 1'b1;
        full_next = (fill_next == FILL_MAX);
    end

    // Delay line, fill tracking, pulse polarity history and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr        <= '0;
            fill      <= '0;
            last_pol  <= POL_NEG;
            data_out  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            sr        <= sr_next;
            fill      <= fill_next;
            out_valid <= full_next;
            data_out  <= sr_next[HDB_N] && full_next;
            if (mark_in) begin
                last_pol <= pol_in;
            end
        end
    end

`ifdef HDB3_ERR_CHK_EN
    hdb3_err_chk #(
        .HDB_N(HDB_N)
    ) u_err_chk (
        .clk     (clk),
        .rst     (rst),
        .pn      (pn),
        .v_det   (v_det),
        .code_err(code_err)
    );
`else
    assign code_err = 1'b0;
`endif

endmodule
